// File: rtl/tcm_port_arb_pkg.sv
// Shared definitions for the TCM data-port arbiter: source IDs and the
// request-valid encoding used by both requesters.
package tcm_port_arb_pkg;

  localparam logic SRC_CORE = 1'b0;
  localparam logic SRC_EXT  = 1'b1;

  // A requester is active when it reads or has any write-byte strobe set.
  function automatic logic req_valid(input logic rd, input logic [3:0] wr);
    return rd | (wr != 4'h0);
  endfunction

endpackage

// File: rtl/tcm_port_arb_if.sv
// Bundle of core, external and TCM data-port signals for tcm_port_arb.
// The dut modport is the arbiter's view, the tb modport the environment's.
interface tcm_port_arb_if;
  logic        c_rd_i;
  logic [3:0]  c_wr_i;
  logic [31:0] c_addr_i;
  logic [31:0] c_data_wr_i;
  logic [10:0] c_req_tag_i;
  logic        c_accept_o;
  logic        c_ack_o;
  logic [31:0] c_data_rd_o;
  logic [10:0] c_resp_tag_o;

  logic        x_rd_i;
  logic [3:0]  x_wr_i;
  logic [31:0] x_addr_i;
  logic [31:0] x_data_wr_i;
  logic [10:0] x_req_tag_i;
  logic        x_accept_o;
  logic        x_ack_o;
  logic [31:0] x_data_rd_o;
  logic [10:0] x_resp_tag_o;

  logic        mem_d_rd_o;
  logic [3:0]  mem_d_wr_o;
  logic [31:0] mem_d_addr_o;
  logic [31:0] mem_d_data_wr_o;
  logic [10:0] mem_d_req_tag_o;
  logic        mem_d_accept_i;
  logic        mem_d_ack_i;
  logic [31:0] mem_d_data_rd_i;
  logic [10:0] mem_d_resp_tag_i;

  modport dut (
    input  c_rd_i, c_wr_i, c_addr_i, c_data_wr_i, c_req_tag_i,
    output c_accept_o, c_ack_o, c_data_rd_o, c_resp_tag_o,
    input  x_rd_i, x_wr_i, x_addr_i, x_data_wr_i, x_req_tag_i,
    output x_accept_o, x_ack_o, x_data_rd_o, x_resp_tag_o,
    output mem_d_rd_o, mem_d_wr_o, mem_d_addr_o, mem_d_data_wr_o, mem_d_req_tag_o,
    input  mem_d_accept_i, mem_d_ack_i, mem_d_data_rd_i, mem_d_resp_tag_i
  );

  modport tb (
    output c_rd_i, c_wr_i, c_addr_i, c_data_wr_i, c_req_tag_i,
    input  c_accept_o, c_ack_o, c_data_rd_o, c_resp_tag_o,
    output x_rd_i, x_wr_i, x_addr_i, x_data_wr_i, x_req_tag_i,
    input  x_accept_o, x_ack_o, x_data_rd_o, x_resp_tag_o,
    input  mem_d_rd_o, mem_d_wr_o, mem_d_addr_o, mem_d_data_wr_o, mem_d_req_tag_o,
    output mem_d_accept_i, mem_d_ack_i, mem_d_data_rd_i, mem_d_resp_tag_i
  );
endinterface

// File: rtl/tcm_port_arb_idfifo.sv
// In-order FIFO of 1-bit source IDs, one entry per request in flight on
// the TCM data port. DEPTH must be a power of two so pointers wrap freely.
module tcm_arb_idfifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     data_i,
  output logic                     data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage, pointer and occupancy update; push and pop may coincide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (pop_i) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;
  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == CW'(0));
endmodule

// File: rtl/tcm_port_arb.sv
// Arbiter sharing one TCM data port between the core and an external
// (loader/debug) requester. Grants and responses are combinational; an ID
// FIFO remembers which source owns each outstanding request.
// Optional macro TCM_ARB_RR_EN: round-robin on contention (default: core wins).
module tcm_port_arb
  import tcm_port_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  tcm_port_arb_if.dut    bus,
  output logic           err_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          w_c_req, w_x_req, w_grant_vld;
  logic          w_pick_src, w_grant_src;
  logic          w_can_accept, w_present, w_fire, w_pop;
  logic          w_head_src, w_full, w_empty;
  logic [CW-1:0] w_count;
  logic          r_hold_vld, r_hold_src, r_err;
`ifdef TCM_ARB_RR_EN
  logic          r_last_grant;
`endif

  assign w_c_req     = req_valid(bus.c_rd_i, bus.c_wr_i);
  assign w_x_req     = req_valid(bus.x_rd_i, bus.x_wr_i);
  assign w_grant_vld = w_c_req | w_x_req;

  // Fresh arbitration decision between the two requesters.
  always_comb begin
    w_pick_src = SRC_CORE;
    if (w_c_req && w_x_req) begin
`ifdef TCM_ARB_RR_EN
      w_pick_src = ~r_last_grant;
`else
      w_pick_src = SRC_CORE;
`endif
    end else if (w_x_req) begin
      w_pick_src = SRC_EXT;
    end else begin
      w_pick_src = SRC_CORE;
    end
  end

  // A stalled grant stays locked to its source while that source still requests.
  always_comb begin
    w_grant_src = w_pick_src;
    if (r_hold_vld && ((r_hold_src == SRC_EXT) ? w_x_req : w_c_req)) begin
      w_grant_src = r_hold_src;
    end else begin
      w_grant_src = w_pick_src;
    end
  end

  // A full tracker can still take a request when an ack frees a slot this cycle.
  assign w_can_accept = (w_count < CW'(DEPTH)) || (w_full && bus.mem_d_ack_i);
  // Only present requests the tracker can record, so the TCM never takes an untracked one.
  assign w_present    = w_grant_vld & w_can_accept;
  assign w_fire       = w_present & bus.mem_d_accept_i & ~rst_i;
  assign w_pop        = bus.mem_d_ack_i & ~w_empty & ~rst_i;

  assign bus.mem_d_rd_o      = w_present & ((w_grant_src == SRC_EXT) ? bus.x_rd_i : bus.c_rd_i);
  assign bus.mem_d_wr_o      = w_present ? ((w_grant_src == SRC_EXT) ? bus.x_wr_i : bus.c_wr_i) : 4'h0;
  assign bus.mem_d_addr_o    = (w_grant_src == SRC_EXT) ? bus.x_addr_i    : bus.c_addr_i;
  assign bus.mem_d_data_wr_o = (w_grant_src == SRC_EXT) ? bus.x_data_wr_i : bus.c_data_wr_i;
  assign bus.mem_d_req_tag_o = (w_grant_src == SRC_EXT) ? bus.x_req_tag_i : bus.c_req_tag_i;

  assign bus.c_accept_o = w_fire & (w_grant_src == SRC_CORE);
  assign bus.x_accept_o = w_fire & (w_grant_src == SRC_EXT);

  assign bus.c_ack_o      = w_pop & (w_head_src == SRC_CORE);
  assign bus.x_ack_o      = w_pop & (w_head_src == SRC_EXT);
  assign bus.c_data_rd_o  = bus.c_ack_o ? bus.mem_d_data_rd_i  : 32'h0;
  assign bus.c_resp_tag_o = bus.c_ack_o ? bus.mem_d_resp_tag_i : 11'h0;
  assign bus.x_data_rd_o  = bus.x_ack_o ? bus.mem_d_data_rd_i  : 32'h0;
  assign bus.x_resp_tag_o = bus.x_ack_o ? bus.mem_d_resp_tag_i : 11'h0;

  tcm_arb_idfifo #(.DEPTH(DEPTH)) u_idfifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_fire),
    .pop_i   (w_pop),
    .data_i  (w_grant_src),
    .data_o  (w_head_src),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Grant lock: remember a presented-but-not-fired grant until it fires.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold_vld <= 1'b0;
      r_hold_src <= SRC_CORE;
    end else if (w_grant_vld && !w_fire) begin
      r_hold_vld <= 1'b1;
      r_hold_src <= w_grant_src;
    end else begin
      r_hold_vld <= 1'b0;
      r_hold_src <= r_hold_src;
    end
  end

`ifdef TCM_ARB_RR_EN
  // Round-robin history: last source that actually issued; ext so core wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_grant <= SRC_EXT;
    end else if (w_fire) begin
      r_last_grant <= w_grant_src;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end
`endif

  // Sticky error: an ack arrived while nothing was outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (bus.mem_d_ack_i && w_empty) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign err_o = r_err;
endmodule

// File: tb/tb_tcm_port_arb.sv
// Scoreboard bench for tcm_port_arb: stimulus pushes expected accepts and
// acks into queues; a monitor pops and compares on every falling edge.
module tb_tcm_port_arb;
  import tcm_port_arb_pkg::*;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
    logic [10:0] tag;
  } ack_t;

  logic clk;
  logic rst_i;
  logic err_o;
  int   checks;
  int   errors;
  logic exp_acc_q[$];
  ack_t exp_ack_q[$];
  logic [3:0] exp_pat;

  tcm_port_arb_if bus ();

  tcm_port_arb #(.DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus.dut),
    .err_o (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.c_rd_i = 1'b0; bus.c_wr_i = 4'h0; bus.c_addr_i = 32'h0;
    bus.c_data_wr_i = 32'h0; bus.c_req_tag_i = 11'h0;
    bus.x_rd_i = 1'b0; bus.x_wr_i = 4'h0; bus.x_addr_i = 32'h0;
    bus.x_data_wr_i = 32'h0; bus.x_req_tag_i = 11'h0;
    bus.mem_d_accept_i = 1'b0; bus.mem_d_ack_i = 1'b0;
    bus.mem_d_data_rd_i = 32'h0; bus.mem_d_resp_tag_i = 11'h0;
  endtask

  task automatic ack(input logic [31:0] d, input logic [10:0] t);
    bus.mem_d_ack_i = 1'b1; bus.mem_d_data_rd_i = d; bus.mem_d_resp_tag_i = t;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  // Scoreboard monitor: compares every accept/ack the DUT presents.
  task automatic monitor();
    logic e;
    ack_t a;
    logic [31:0] d;
    logic [10:0] t;
    forever begin
      @(negedge clk);
      if (bus.c_accept_o || bus.x_accept_o) begin
        checks++;
        if (exp_acc_q.size() == 0) begin
          errors++;
          $display("FAIL accept_unexpected: got c=%0b x=%0b expected none", bus.c_accept_o, bus.x_accept_o);
        end else begin
          e = exp_acc_q.pop_front();
          if ({bus.c_accept_o, bus.x_accept_o} !== ((e == SRC_EXT) ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL accept_src: got c=%0b x=%0b expected src=%0b", bus.c_accept_o, bus.x_accept_o, e);
          end
        end
      end
      if (bus.c_ack_o || bus.x_ack_o) begin
        checks++;
        d = bus.c_ack_o ? bus.c_data_rd_o : bus.x_data_rd_o;
        t = bus.c_ack_o ? bus.c_resp_tag_o : bus.x_resp_tag_o;
        if (exp_ack_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected: got c=%0b x=%0b expected none", bus.c_ack_o, bus.x_ack_o);
        end else begin
          a = exp_ack_q.pop_front();
          if ({bus.c_ack_o, bus.x_ack_o} !== ((a.src == SRC_EXT) ? 2'b01 : 2'b10) ||
              d !== a.data || t !== a.tag) begin
            errors++;
            $display("FAIL ack_resp: got c=%0b x=%0b data=%0h tag=%0h expected src=%0b data=%0h tag=%0h",
                     bus.c_ack_o, bus.x_ack_o, d, t, a.src, a.data, a.tag);
          end
        end
      end
      checks++;
      if ((!bus.c_ack_o && (bus.c_data_rd_o !== 32'h0 || bus.c_resp_tag_o !== 11'h0)) ||
          (!bus.x_ack_o && (bus.x_data_rd_o !== 32'h0 || bus.x_resp_tag_o !== 11'h0))) begin
        errors++;
        $display("FAIL idle_resp_zero: got c=%0h/%0h x=%0h/%0h expected 0 when not acked",
                 bus.c_data_rd_o, bus.c_resp_tag_o, bus.x_data_rd_o, bus.x_resp_tag_o);
      end
    end
  endtask

  task automatic run_tests();
    // Reset: outputs quiet even with requests and acks present.
    idle();
    rst_i = 1'b1;
    step();
    bus.c_rd_i = 1'b1; bus.mem_d_accept_i = 1'b1; ack(32'h1, 11'h1);
    @(negedge clk);
    chk("rst_quiet", {bus.c_accept_o, bus.x_accept_o, bus.c_ack_o, bus.x_ack_o}, 4'h0);
    step();
    idle();
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_err", err_o, 1'b0);

    // Single core read, ack next cycle with zero added latency.
    step();
    bus.c_rd_i = 1'b1; bus.c_addr_i = 32'h100; bus.mem_d_accept_i = 1'b1;
    exp_acc_q.push_back(SRC_CORE);
    @(negedge clk);
    chk("c0_mem_rd", bus.mem_d_rd_o, 1'b1);
    chk("c0_mem_addr", bus.mem_d_addr_o, 32'h100);
    step();
    idle();
    ack(32'hDEADBEEF, 11'h05);
    exp_ack_q.push_back('{SRC_CORE, 32'hDEADBEEF, 11'h05});
    step();
    idle();

    // Both request continuously for four cycles.
`ifdef TCM_ARB_RR_EN
    exp_pat = 4'b1010;
`else
    exp_pat = 4'b0000;
`endif
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step();
      idle();
      bus.c_rd_i = 1'b1; bus.c_addr_i = 32'h200;
      bus.x_rd_i = 1'b1; bus.x_addr_i = 32'h300;
      bus.mem_d_accept_i = 1'b1;
      exp_acc_q.push_back(exp_pat[k]);
      if (k > 0) begin
        ack(32'h1000 + 32'(k - 1), 11'(k - 1));
        exp_ack_q.push_back('{exp_pat[k-1], 32'h1000 + 32'(k - 1), 11'(k - 1)});
      end
      @(negedge clk);
      chk("both_addr", bus.mem_d_addr_o, exp_pat[k] ? 32'h300 : 32'h200);
    end
    step();
    idle();
    ack(32'h1003, 11'h3);
    exp_ack_q.push_back('{exp_pat[3], 32'h1003, 11'h3});

    // Tracker full at DEPTH=2; ack frees a slot in the same cycle.
    step();
    idle();
    bus.c_rd_i = 1'b1; bus.mem_d_accept_i = 1'b1;
    exp_acc_q.push_back(SRC_CORE);
    step();
    exp_acc_q.push_back(SRC_CORE);
    step();
    @(negedge clk);
    chk("full_stall", bus.c_accept_o, 1'b0);
    step();
    ack(32'hA0, 11'h10);
    exp_acc_q.push_back(SRC_CORE);
    exp_ack_q.push_back('{SRC_CORE, 32'hA0, 11'h10});
    @(negedge clk);
    chk("full_pushpop", bus.c_accept_o, 1'b1);
    step();
    bus.mem_d_ack_i = 1'b0;
    @(negedge clk);
    chk("count_stays2", bus.c_accept_o, 1'b0);
    step();
    idle();
    ack(32'hA1, 11'h11);
    exp_ack_q.push_back('{SRC_CORE, 32'hA1, 11'h11});
    step();
    ack(32'hA2, 11'h12);
    exp_ack_q.push_back('{SRC_CORE, 32'hA2, 11'h12});

    // TCM back-pressure on an ext write; grant stays with ext.
    step();
    idle();
    bus.x_wr_i = 4'hF; bus.x_addr_i = 32'h400; bus.x_data_wr_i = 32'h55;
    @(negedge clk);
    chk("bp_x_accept", bus.x_accept_o, 1'b0);
    step();
    bus.c_rd_i = 1'b1; bus.c_addr_i = 32'h500;
    @(negedge clk);
    chk("bp_hold_wr", {bus.mem_d_rd_o, bus.mem_d_wr_o}, 5'h0F);
    chk("bp_hold_addr", bus.mem_d_addr_o, 32'h400);
    step();
    bus.mem_d_accept_i = 1'b1;
    exp_acc_q.push_back(SRC_EXT);
    @(negedge clk);
    chk("bp_release", bus.x_accept_o, 1'b1);
    step();
    bus.x_wr_i = 4'h0;
    exp_acc_q.push_back(SRC_CORE);
    step();
    idle();
    ack(32'hB0, 11'h20);
    exp_ack_q.push_back('{SRC_EXT, 32'hB0, 11'h20});
    step();
    ack(32'hB1, 11'h21);
    exp_ack_q.push_back('{SRC_CORE, 32'hB1, 11'h21});
    step();
    idle();
    @(negedge clk);
    chk("no_err_yet", err_o, 1'b0);

    // Stray ack: sticky error, cleared only by reset.
    step();
    ack(32'hC0, 11'h30);
    @(negedge clk);
    chk("err_same_cycle", err_o, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk("err_set", err_o, 1'b1);
    step();
    step();
    @(negedge clk);
    chk("err_sticky", err_o, 1'b1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", err_o, 1'b0);

    // Reset with two outstanding: later acks route nowhere and flag error.
    step();
    bus.c_rd_i = 1'b1; bus.mem_d_accept_i = 1'b1;
    exp_acc_q.push_back(SRC_CORE);
    step();
    exp_acc_q.push_back(SRC_CORE);
    step();
    idle();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    ack(32'hD0, 11'h40);
    @(negedge clk);
    chk("post_rst_ack1", {bus.c_ack_o, bus.x_ack_o}, 2'b00);
    step();
    ack(32'hD1, 11'h41);
    @(negedge clk);
    chk("post_rst_ack2", {bus.c_ack_o, bus.x_ack_o}, 2'b00);
    step();
    idle();
    @(negedge clk);
    chk("post_rst_err", err_o, 1'b1);
    step();

    chk("acc_q_drained", 64'(exp_acc_q.size()), 64'h0);
    chk("ack_q_drained", 64'(exp_ack_q.size()), 64'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_i  = 1'b1;
    idle();
    fork
      monitor();
      run_tests();
      begin
        #20000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
